// File: rtl/hex_link_host.sv
// hex_link_host: streams 352-bit jobs to a UART as uppercase hex lines and decodes
// hex reply lines into golden nonces and temperature reports.
module hex_link_host (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_blockdata,
    output logic         tx_new_byte,
    output logic [7:0]   tx_byte,
    input  logic         tx_ready,
    input  logic         rx_new_byte,
    input  logic [7:0]   rx_byte,
    output logic         nonce_valid,
    output logic [31:0]  nonce,
    output logic         temp_valid,
    output logic [15:0]  temp,
    output logic         line_error
);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GUARD = 2'd2, DONE = 2'd3;
    logic [1:0]   state;
    logic [351:0] job;
    logic [6:0]   cnt;
    logic [3:0]   nib;
    logic [31:0]  acc;
    logic [3:0]   rcnt;
    logic         bad;
    logic         is_hex;
    logic [3:0]   dig;
    assign work_ready = state == IDLE;
    // job is shifted down one byte after its low nibble goes out, so the current byte is always job[7:0]
    always_comb begin
        nib = cnt[0] ? job[3:0] : job[7:4];
        tx_new_byte = state == SEND && tx_ready;
        tx_byte = !tx_new_byte ? 8'h00 : cnt == 7'd88 ? 8'h0A :
                  nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            job <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (work_valid) begin
                    job <= {work_midstate, work_blockdata};
                    cnt <= '0;
                    state <= SEND;
                end
                SEND: if (tx_ready) begin
                    if (cnt == 7'd88) state <= DONE;
                    else begin
                        state <= GUARD;
                        cnt <= cnt + 7'd1;
                        if (cnt[0]) job <= job >> 8;
                    end
                end
                GUARD: state <= SEND;
                default: begin
                    state <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end
    always_comb begin
        is_hex = rx_byte inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]};
        dig = rx_byte[6] ? rx_byte[3:0] + 4'd9 : rx_byte[3:0];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            rcnt <= '0;
            bad <= 1'b0;
            nonce <= '0;
            temp <= '0;
            nonce_valid <= 1'b0;
            temp_valid <= 1'b0;
            line_error <= 1'b0;
        end else begin
            nonce_valid <= 1'b0;
            temp_valid <= 1'b0;
            line_error <= 1'b0;
            if (rx_new_byte) begin
                if (is_hex) begin
                    acc <= {acc[27:0], dig};
                    rcnt <= rcnt == 4'd15 ? rcnt : rcnt + 4'd1;
                end else if (rx_byte == 8'h0A) begin
                    if (!bad && rcnt == 4'd8) begin
                        nonce <= acc;
                        nonce_valid <= 1'b1;
                    end else if (!bad && rcnt == 4'd4) begin
                        temp <= acc[15:0];
                        temp_valid <= 1'b1;
                    end else if (bad || rcnt != 4'd0) line_error <= 1'b1;
                    acc <= '0;
                    rcnt <= '0;
                    bad <= 1'b0;
                end else if (rx_byte != 8'h0D) bad <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hex_link_host.sv
// tb_hex_link_host: randomized scoreboard bench for hex_link_host against a line/byte-level model.
module tb_hex_link_host;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_blockdata;
    logic         tx_new_byte;
    logic [7:0]   tx_byte;
    logic         tx_ready;
    logic         rx_new_byte;
    logic [7:0]   rx_byte;
    logic         nonce_valid;
    logic [31:0]  nonce;
    logic         temp_valid;
    logic [15:0]  temp;
    logic         line_error;

    hex_link_host dut (
        .clk(clk), .reset_n(reset_n), .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_blockdata(work_blockdata),
        .tx_new_byte(tx_new_byte), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .rx_new_byte(rx_new_byte), .rx_byte(rx_byte), .nonce_valid(nonce_valid),
        .nonce(nonce), .temp_valid(temp_valid), .temp(temp), .line_error(line_error)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; logic [31:0] val;} ev_t;
    logic [7:0] exp_tx[$];
    ev_t        exp_rx[$];
    logic [7:0] line[$];
    logic [31:0] m_nonce = 0;
    logic [15:0] m_temp = 0;
    int n_cmp = 0, n_err = 0;
    int mode = 0;
    bit check_gap = 0;
    int cyc = 0;
    string hx = "0123456789ABCDEF";
    string digs = "0123456789ABCDEFabcdef";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // tx_ready is owned here; mode 0 = always ready, 1 = stalled, 2 = random
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: pops expectations whenever the DUT strobes or pulses
    initial begin
        int pos = 0, last = 0;
        logic [7:0] eb;
        ev_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                pos = 0;
                continue;
            end
            if (tx_new_byte) begin
                chk("tx_ready_gate", tx_ready, 1);
                if (exp_tx.size() == 0) chk("tx_extra_byte", tx_byte, 8'hFF);
                else begin
                    eb = exp_tx.pop_front();
                    chk("tx_byte", tx_byte, eb);
                end
                if (check_gap && pos > 0) chk("tx_gap", cyc - last, 2);
                last = cyc;
                pos = tx_byte == 8'h0A ? 0 : pos + 1;
            end
            if (nonce_valid || temp_valid || line_error) begin
                if (exp_rx.size() == 0) chk("rx_extra_pulse", {nonce_valid, temp_valid, line_error}, 0);
                else begin
                    e = exp_rx.pop_front();
                    chk("rx_pulse_kind", {nonce_valid, temp_valid, line_error},
                        e.kind == 0 ? 3'b100 : e.kind == 1 ? 3'b010 : 3'b001);
                    if (e.kind == 0) chk("nonce", nonce, e.val);
                    if (e.kind == 1) chk("temp", temp, e.val);
                    if (e.kind == 2) begin
                        chk("nonce_held", nonce, m_nonce);
                        chk("temp_held", temp, m_temp);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] hexval(input logic [7:0] c);
        return c >= "a" ? 4'(c - 8'd87) : c >= "A" ? 4'(c - 8'd55) : 4'(c - 8'd48);
    endfunction

    function automatic bit ishex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_new_byte = 1'b1;
        @(posedge clk);
        #1;
        rx_new_byte = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // model of a whole line: count digits, note any stray byte, classify at newline
    task automatic send_line();
        bit b = 0;
        int n = 0;
        logic [31:0] v = 0;
        ev_t e;
        foreach (line[i]) begin
            if (ishex(line[i])) begin
                v = {v[27:0], hexval(line[i])};
                n++;
            end else if (line[i] != 8'h0D) b = 1;
            send_byte(line[i]);
        end
        if (!b && n == 8) begin
            e.kind = 0; e.val = v; m_nonce = v; exp_rx.push_back(e);
        end else if (!b && n == 4) begin
            e.kind = 1; e.val = {16'h0, v[15:0]}; m_temp = v[15:0]; exp_rx.push_back(e);
        end else if (b || n != 0) begin
            e.kind = 2; e.val = 0; exp_rx.push_back(e);
        end
        send_byte(8'h0A);
    endtask

    task automatic set_line(input string s);
        line.delete();
        for (int i = 0; i < s.len(); i++) line.push_back(s[i]);
    endtask

    task automatic rand_line();
        int k = $urandom_range(0, 4);
        int n = k == 0 || k == 3 ? 8 : k == 1 || k == 4 ? 4 : $urandom_range(0, 12);
        line.delete();
        for (int i = 0; i < n; i++) line.push_back(digs[$urandom_range(0, 21)]);
        if (k == 3) line.insert($urandom_range(0, 8), 8'(8'h20 + $urandom_range(0, 15)));
        if (k == 4) line.push_back(8'h0D);
    endtask

    task automatic submit(input logic [351:0] j);
        logic [7:0] b;
        int t = 0;
        @(posedge clk);
        #1;
        while (!work_ready && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!work_ready) chk("ready_wait_timeout", 0, 1);
        for (int i = 0; i < 44; i++) begin
            b = j[i*8 +: 8];
            exp_tx.push_back(hx[b[7:4]]);
            exp_tx.push_back(hx[b[3:0]]);
        end
        exp_tx.push_back(8'h0A);
        {work_midstate, work_blockdata} = j;
        work_valid = 1'b1;
        @(posedge clk);
        #1;
        work_valid = 1'b0;
        chk("ready_low_after_accept", work_ready, 0);
    endtask

    task automatic wait_tx_left(input int left);
        int t = 0;
        while (exp_tx.size() > left && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_tx.size() > left) chk("tx_progress_timeout", exp_tx.size(), left);
    endtask

    task automatic wait_tx_done();
        int t = 0;
        wait_tx_left(0);
        while (!work_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("ready_after_newline", work_ready, 1);
    endtask

    function automatic logic [351:0] rand_job();
        logic [351:0] j;
        for (int i = 0; i < 11; i++) j[i*32 +: 32] = $urandom;
        return j;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_work_ready"}, work_ready, 1);
        chk({tag, "_tx_new_byte"}, tx_new_byte, 0);
        chk({tag, "_tx_byte"}, tx_byte, 0);
        chk({tag, "_nonce_valid"}, nonce_valid, 0);
        chk({tag, "_nonce"}, nonce, 0);
        chk({tag, "_temp_valid"}, temp_valid, 0);
        chk({tag, "_temp"}, temp, 0);
        chk({tag, "_line_error"}, line_error, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        work_valid = 1'b0;
        work_midstate = '0;
        work_blockdata = '0;
        rx_new_byte = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        check_gap = 1;
        submit({256'h0, 96'hA5C3});
        wait_tx_done();
        check_gap = 0;

        submit(rand_job());
        wait_tx_left(60);
        @(posedge clk);
        #1;
        mode = 1;
        repeat (52) @(posedge clk);
        #1;
        mode = 0;
        wait_tx_done();

        set_line("DEADbeef"); send_line();
        set_line("0A1F\r"); send_line();
        set_line("12G45678"); send_line();
        set_line("123"); send_line();
        set_line(""); send_line();

        fork
            begin
                mode = 2;
                repeat (6) begin
                    submit(rand_job());
                    wait_tx_done();
                end
                mode = 0;
            end
            repeat (150) begin
                rand_line();
                send_line();
            end
        join
        repeat (5) @(posedge clk);

        submit(rand_job());
        set_line("12");
        foreach (line[i]) send_byte(line[i]);
        wait_tx_left(79);
        @(negedge clk);
        reset_n = 1'b0;
        exp_tx.delete();
        m_nonce = 0;
        m_temp = 0;
        repeat (3) @(negedge clk);
        check_reset_values("midjob_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        set_line(""); send_line();
        submit(rand_job());
        wait_tx_done();

        repeat (10) @(negedge clk);
        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("final_nonce", nonce, m_nonce);
        chk("final_temp", temp, m_temp);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
